text_writer: RTL

- Byte-stream terminal writer: accepts ASCII bytes over a valid/ready handshake and writes them into the 80x25 screen RAM that the text-mode display scans.
- Maintains a cursor and handles CR, LF, BS and FF.
- Scrolls the screen up one row when a newline occurs on the last row.
- Drives the RAM write-side port: address, data, write enable, and read-data return for scroll copies.

---
 rtl/text_writer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/text_writer.sv
// text_writer: byte-stream terminal writer for an 80x25 text-mode screen RAM.
// Accepts bytes over valid/ready, keeps a cursor, handles CR/LF/BS/FF and
// scrolls the screen up one row when a newline happens on the last row.
// Optional build macro TEXT_WRITER_CLEAR_ON_RST_EN: reset enters CLEAR so the
// screen is blanked before the first byte is accepted.
module text_writer #(
    parameter int         COLS      = 80,
    parameter int         ROWS      = 25,
    parameter logic [7:0] BLANK_CHR = 8'h20
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic [7:0]  char_i,
    input  logic        char_valid_i,
    output logic        char_ready_o,
    output logic [11:0] ram_addr_o,
    output logic [7:0]  ram_data_o,
    output logic        ram_wren_o,
    input  logic [7:0]  ram_q_i,
    output logic [6:0]  cursor_x_o,
    output logic [4:0]  cursor_y_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        PUT,
        SCROLL_RD,
        SCROLL_WR,
        CLEAR
    } state_t;

    localparam logic [6:0] COL_LAST = 7'(COLS - 1);
    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

`ifdef TEXT_WRITER_CLEAR_ON_RST_EN
    localparam state_t RST_STATE = CLEAR;
    localparam logic   RST_READY = 1'b0;
`else
    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_READY = 1'b1;
`endif

    state_t     state_reg, state_next;
    logic [6:0] x_reg, x_next;        // cursor column
    logic [4:0] y_reg, y_next;        // cursor row
    logic [6:0] c_reg, c_next;        // sweep column for scroll/clear
    logic [4:0] r_reg, r_next;        // sweep row for scroll/clear
    logic [7:0] char_reg, char_next;  // byte to be written in PUT
    logic       bs_reg, bs_next;      // PUT is a backspace blanking, no advance
    logic       fill_reg, fill_next;  // scroll copy done, blanking the last row
    logic       ready_reg;
    logic       accept;

    assign accept       = char_valid_i & ready_reg;
    assign char_ready_o = ready_reg;
    assign cursor_x_o   = x_reg;
    assign cursor_y_o   = y_reg;
    assign busy_o       = (state_reg == SCROLL_RD) || (state_reg == SCROLL_WR) ||
                          (state_reg == CLEAR);

    // State and datapath registers; ready is registered off the next state.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_reg <= RST_STATE;
            x_reg     <= '0;
            y_reg     <= '0;
            c_reg     <= '0;
            r_reg     <= '0;
            char_reg  <= '0;
            bs_reg    <= 1'b0;
            fill_reg  <= 1'b0;
            ready_reg <= RST_READY;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            c_reg     <= c_next;
            r_reg     <= r_next;
            char_reg  <= char_next;
            bs_reg    <= bs_next;
            fill_reg  <= fill_next;
            ready_reg <= (state_next == IDLE);
        end
    end

    // Next-state, cursor update and RAM port drive.
    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        c_next     = c_reg;
        r_next     = r_reg;
        char_next  = char_reg;
        bs_next    = bs_reg;
        fill_next  = fill_reg;
        ram_addr_o = '0;
        ram_data_o = '0;
        ram_wren_o = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    case (char_i)
                        8'h0D: x_next = '0;
                        8'h0A: begin
                            x_next = '0;
                            if (y_reg < ROW_LAST) begin
                                y_next = y_reg + 5'd1;
                            end else begin
                                state_next = SCROLL_RD;
                                r_next     = 5'd1;
                                c_next     = '0;
                                fill_next  = 1'b0;
                            end
                        end
                        8'h08: begin
                            // Backspace never wraps to the previous row.
                            if (x_reg != '0) begin
                                x_next     = x_reg - 7'd1;
                                char_next  = BLANK_CHR;
                                bs_next    = 1'b1;
                                state_next = PUT;
                            end
                        end
                        8'h0C: begin
                            x_next     = '0;
                            y_next     = '0;
                            r_next     = '0;
                            c_next     = '0;
                            state_next = CLEAR;
                        end
                        default: begin
                            // Remaining control codes and DEL are dropped.
                            if ((char_i >= 8'h20) && (char_i != 8'h7F)) begin
                                char_next  = char_i;
                                bs_next    = 1'b0;
                                state_next = PUT;
                            end
                        end
                    endcase
                end
            end

            PUT: begin
                ram_wren_o = 1'b1;
                ram_addr_o = {y_reg, x_reg};
                ram_data_o = char_reg;
                state_next = IDLE;
                if (!bs_reg) begin
                    if (x_reg < COL_LAST) begin
                        x_next = x_reg + 7'd1;
                    end else begin
                        x_next = '0;
                        if (y_reg < ROW_LAST) begin
                            y_next = y_reg + 5'd1;
                        end else begin
                            state_next = SCROLL_RD;
                            r_next     = 5'd1;
                            c_next     = '0;
                            fill_next  = 1'b0;
                        end
                    end
                end
            end

            SCROLL_RD: begin
                // Read {r,c}; the RAM returns it next cycle for the copy.
                ram_addr_o = {r_reg, c_reg};
                state_next = SCROLL_WR;
            end

            SCROLL_WR: begin
                ram_wren_o = 1'b1;
                if (fill_reg) begin
                    ram_addr_o = {ROW_LAST, c_reg};
                    ram_data_o = BLANK_CHR;
                    if (c_reg == COL_LAST) begin
                        c_next     = '0;
                        fill_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        c_next = c_reg + 7'd1;
                    end
                end else begin
                    ram_addr_o = {5'(r_reg - 5'd1), c_reg};
                    ram_data_o = ram_q_i;
                    state_next = SCROLL_RD;
                    if (c_reg == COL_LAST) begin
                        c_next = '0;
                        if (r_reg == ROW_LAST) begin
                            // Copy finished; blank the bottom row back-to-back.
                            fill_next  = 1'b1;
                            state_next = SCROLL_WR;
                        end else begin
                            r_next = r_reg + 5'd1;
                        end
                    end else begin
                        c_next = c_reg + 7'd1;
                    end
                end
            end

            CLEAR: begin
                ram_wren_o = 1'b1;
                ram_addr_o = {r_reg, c_reg};
                ram_data_o = BLANK_CHR;
                if (c_reg == COL_LAST) begin
                    c_next = '0;
                    if (r_reg == ROW_LAST) begin
                        r_next     = '0;
                        state_next = IDLE;
                    end else begin
                        r_next = r_reg + 5'd1;
                    end
                end else begin
                    c_next = c_reg + 7'd1;
                end
            end

            default: state_next = IDLE;
        endcase
    end

endmodule
